bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the serial pattern-detection FSMs.
- Accepts WIDTH-bit words through a valid/ready handshake and drives them out one bit per clock on `w`, the single-bit input consumed directly by the downstream detector FSM.
- Back-to-back words stream with no gap, so a pattern straddling a word boundary is still seen downstream.
- Idle cycles drive a fixed idle level, which breaks any run in progress.

## Interface
Parameters:
- WIDTH, 8, word length in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 shifted out first; 0 = bit 0 first.
- IDLE_LEVEL, 1'b0, value driven on `w` when no word is shifting.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  rising-edge clock.
  - rst  in  1  asynchronous active-high reset.
- din  in  WIDTH  word to serialize; sampled on accept.
- load_valid  in  1  producer offers `din`.
- load_ready  out  1  block can accept a word this cycle.
- w  out  1  serial bit stream to the detector.
- w_valid  out  1  `w` carries a data bit this cycle.
- w_last  out  1  `w` carries the final bit of a word.

## Operation
- Accept: occurs on a clk edge where load_valid && load_ready. load_ready = !pend_full, combinational from registered state only, with no path from load_valid.
- Storage:
  - Shift register shreg[WIDTH-1:0].
  - Bit counter cnt, $clog2(WIDTH) bits wide.
  - One-entry holding register pend plus flag pend_full.
- FSM states:
  - IDLE: not shifting.
  - SHIFT: a word occupies shreg.
- IDLE:
  - An accepted word loads shreg directly; cnt = 0; next state SHIFT.
  - pend is never written in IDLE.
- SHIFT, each clock:
  - Advance shreg by one bit toward the output end; cnt increments.
  - Last-bit edge, i.e. the edge ending the bit where cnt == WIDTH-1. The next source is chosen in priority order:
    1. If pend_full, load pend into shreg, clear pend_full, cnt = 0, stay in SHIFT.
    2. Else, if a word is accepted this same edge, load din into shreg (bypass), cnt = 0, stay in SHIFT.
    3. Else, go to IDLE.
  - Non-last edge: an accepted word is written into pend and pend_full is set.
  - Simultaneous pend drain and new accept: cannot occur, because load_ready = 0 whenever pend_full.
- Outputs are registered and reflect the current shreg/cnt/state:
  - w = output end of shreg in SHIFT, IDLE_LEVEL in IDLE.
  - w_valid = (state == SHIFT).
  - w_last = (state == SHIFT && cnt == WIDTH-1).
- Not supported: no backpressure from downstream. The detector samples `w` every clock.

## Timing
- Reset values:
  - state IDLE, cnt 0, shreg 0, pend_full 0.
  - w = IDLE_LEVEL, w_valid 0, w_last 0, load_ready 1.
- Reset mid-operation: the word in flight and any pending word are discarded immediately (asynchronous). After release, the next accepted word starts at its first bit.
- Latency: word accepted at edge k drives its first bit in the cycle after edge k. Its WIDTH bits occupy cycles k+1 .. k+WIDTH, with w_last in cycle k+WIDTH.
- Throughput: one bit per clock. A word accepted at or before the last-bit edge of the current word follows with zero idle cycles.
- load_ready: falls the cycle after a word lands in pend. It rises the cycle after that word moves into shreg.
- A producer holding load_valid with load_ready low must keep din stable; no word is lost or duplicated.

## Structure
- Shared package `ser_pkg`:
  - State encoding constants S_IDLE = 1'b0, S_SHIFT = 1'b1.
  - Helper constant for the counter width.
- One sub-module is natural: `ser_hold_reg`, the one-entry holding register with pend_full, load and drain strobes.
- The FSM, counter and shift register stay in the top module.

## Test plan
All scenarios use WIDTH=8, MSB_FIRST=1, IDLE_LEVEL=0 unless noted.
- Single word: reset, then accept 8'hA5 at edge k -> w = 1,0,1,0,0,1,0,1 in cycles k+1..k+8, w_valid high exactly those 8 cycles, w_last only in k+8, then w=0 and w_valid=0.
- Back-to-back: accept 8'h81, then 8'hC0 while 8'h81 is shifting -> 16 contiguous valid bits. load_ready is low from the cycle after the second accept until the first word's last-bit edge. Downstream detector sees the 1,1 run across the boundary, and z asserts.
- Stall: pend_full and load_valid held with 8'h3C -> no accept while load_ready is 0. Exactly one accept of 8'h3C once load_ready rises. Its bits follow the pending word with no gap.
- Idle gap: accept 8'h01, wait 3 idle cycles, accept 8'h80 -> `w` shows 0s between the two words, and the downstream detector does not assert z.
- Reset mid-word: assert rst during the 4th bit of 8'hFF with 8'h0F pending -> w=0, w_valid=0, w_last=0 and load_ready=1 immediately. After release, accept 8'hF0 -> bits 1,1,1,1,0,0,0,0 with no residue of 8'hFF or 8'h0F.
- LSB-first: MSB_FIRST=0, accept 8'h03 -> w = 1,1,0,0,0,0,0,0.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and counter sizing.
package ser_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  // Bit counter width for a given word length (WIDTH >= 2).
  function automatic int ser_cnt_bits(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-entry holding register for a word that arrives while another is shifting.
module ser_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (load) begin
        data <= load_data;
        full <= 1'b1;
      end else if (drain) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: streams accepted words one bit per clock on w,
// chaining a pending word onto the current one with no idle gap.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             w,
  output logic             w_valid,
  output logic             w_last
);

  localparam int             CW       = ser_cnt_bits(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg_shifted;
  logic [WIDTH-1:0] pend_data;
  logic             pend_full;
  logic             accept;
  logic             last_bit;
  logic             pend_load;
  logic             pend_drain;
  logic             out_bit;

  // Ready depends only on registered state, so a producer never sees a loop through load_valid.
  assign load_ready = !pend_full;
  assign accept     = load_valid && load_ready;
  assign last_bit   = (state == S_SHIFT) && (cnt == CNT_LAST);
  assign pend_load  = accept && (state == S_SHIFT) && !last_bit;
  assign pend_drain = last_bit && pend_full;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
      assign out_bit       = shreg[WIDTH-1];
    end else begin : g_lsb
      assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
      assign out_bit       = shreg[0];
    end
  endgenerate

  ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (pend_load),
    .load_data (din),
    .drain     (pend_drain),
    .data      (pend_data),
    .full      (pend_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            shreg <= din;
            cnt   <= '0;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (last_bit) begin
            // A held word takes priority over a same-edge bypass of din.
            cnt <= '0;
            if (pend_full) begin
              shreg <= pend_data;
            end else if (accept) begin
              shreg <= din;
            end else begin
              shreg <= '0;
              state <= S_IDLE;
            end
          end else begin
            shreg <= shreg_shifted;
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs are decoded purely from registered state.
  assign w       = (state == S_SHIFT) ? out_bit : IDLE_LEVEL;
  assign w_valid = (state == S_SHIFT);
  assign w_last  = last_bit;

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized + directed bench for bit_serializer against a cycle-schedule reference model.
module tb_bit_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         load_valid;
  logic         load_ready;
  logic         w, w_valid, w_last;

  logic [W-1:0] din2;
  logic         load_valid2;
  logic         load_ready2;
  logic         w2, w_valid2, w_last2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: every accepted word is scheduled to cycles start..start+W-1.
  int exp_bit  [int];
  int exp_last [int];
  int last_end   = -100;
  int last_acc   = -100;
  int last_start = -100;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .w          (w),
    .w_valid    (w_valid),
    .w_last     (w_last)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .din        (din2),
    .load_valid (load_valid2),
    .load_ready (load_ready2),
    .w          (w2),
    .w_valid    (w_valid2),
    .w_last     (w_last2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // A word is pending (not yet started) between its accept cycle and its start cycle.
  function automatic bit model_ready(input int c);
    return !(last_acc < c && last_start > c);
  endfunction

  task automatic model_reset();
    exp_bit.delete();
    exp_last.delete();
    last_end   = -100;
    last_acc   = -100;
    last_start = -100;
  endtask

  // Called at posedge+1: drive inputs, check cycle outputs at negedge, update model, advance.
  task automatic step(input logic v, input logic [W-1:0] d, output bit acc);
    int c, start;
    load_valid = v;
    din        = d;
    @(negedge clk);
    c = cyc;
    if (exp_bit.exists(c)) begin
      chk("w",       32'(w),       32'(exp_bit[c]));
      chk("w_valid", 32'(w_valid), 32'd1);
      chk("w_last",  32'(w_last),  32'(exp_last[c]));
    end else begin
      chk("w_idle",       32'(w),       32'd0);
      chk("w_valid_idle", 32'(w_valid), 32'd0);
      chk("w_last_idle",  32'(w_last),  32'd0);
    end
    chk("load_ready", 32'(load_ready), 32'(model_ready(c)));
    acc = v && model_ready(c) && !rst;
    if (acc) begin
      start = (c + 1 > last_end + 1) ? c + 1 : last_end + 1;
      for (int i = 0; i < W; i++) begin
        exp_bit[start + i]  = (d >> (W - 1 - i)) & 1;
        exp_last[start + i] = (i == W - 1);
      end
      last_end   = start + W - 1;
      last_acc   = c;
      last_start = start;
      $display("accept word=%02h cyc=%0d first_bit_cyc=%0d", d, c, start);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, a);
  endtask

  initial begin
    bit a;
    bit hv;
    logic [W-1:0] hd;
    rst = 1'b1; din = '0; load_valid = 1'b0; din2 = '0; load_valid2 = 1'b0;
    @(posedge clk); #1;
    idle(2);
    rst = 1'b0;
    idle(2);

    // Single word
    step(1'b1, 8'hA5, a);
    idle(10);

    // Back-to-back across a word boundary
    step(1'b1, 8'h81, a);
    idle(1);
    step(1'b1, 8'hC0, a);
    idle(18);

    // Stall: hold 8'h3C while the holding register is full
    step(1'b1, 8'h11, a);
    step(1'b1, 8'h22, a);
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) step(1'b1, 8'h3C, a);
    chk("stall_accept", 32'(a), 32'd1);
    idle(20);

    // Idle gap between words
    step(1'b1, 8'h01, a);
    idle(10);
    step(1'b1, 8'h80, a);
    idle(10);

    // Reset during the 4th bit of 8'hFF with 8'h0F pending
    step(1'b1, 8'hFF, a);
    step(1'b1, 8'h0F, a);
    idle(2);
    rst = 1'b1;
    #1;
    chk("rst_w",          32'(w),          32'd0);
    chk("rst_w_valid",    32'(w_valid),    32'd0);
    chk("rst_w_last",     32'(w_last),     32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd1);
    model_reset();
    @(posedge clk); #1;
    idle(1);
    rst = 1'b0;
    step(1'b1, 8'hF0, a);
    idle(12);

    // Randomized traffic; an offered word is held stable until accepted
    hv = 1'b0; hd = '0; a = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (!hv || a) begin
        hv = ($urandom_range(0, 99) < 55);
        hd = W'($urandom);
      end
      step(hv, hd, a);
    end
    idle(20);

    // LSB-first instance
    load_valid2 = 1'b1; din2 = 8'h03;
    @(negedge clk);
    chk("lsb_ready", 32'(load_ready2), 32'd1);
    @(posedge clk); #1;
    load_valid2 = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("lsb_w",       32'(w2),       32'((8'h03 >> i) & 1));
      chk("lsb_w_valid", 32'(w_valid2), 32'd1);
      chk("lsb_w_last",  32'(w_last2),  32'(i == W - 1));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("lsb_idle", 32'(w_valid2), 32'd0);
    $display("lsb word=03 checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
